// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the simple CPU datapath.
// Sequences each instruction through IF/ID/EX/MEM/WB, drives datapath
// enables and mux selects, and counts retired instructions.
// Optional feature macro: CTRL_SHIFT_EN enables sll/srl/sllv/srlv/lui;
// when it is undefined those encodings are reported as illegal.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RFWr,
  output logic             DMWr,
  output logic             DMRd,
  output logic [1:0]       NPCOp,
  output logic [3:0]       ALUop,
  output logic             ALUSrcB,
  output logic             EXTOp,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    K_ILL, K_R, K_JR, K_J, K_JAL, K_BEQ, K_LW, K_SW, K_IMM
  } kind_t;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
`ifdef CTRL_SHIFT_EN
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SLLV = 4'd9;
  localparam logic [3:0] ALU_SRLV = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
`endif

  state_t     state, next_state;
  kind_t      kind;
  logic [3:0] dec_alu;
  logic       dec_srcb, dec_ext;

  logic       pc_wr, ir_wr, rf_wr, dm_wr, dm_rd, ill, retire;
  logic [1:0] npc_op, gpr_sel, wd_sel;
  logic [3:0] alu_op;
  logic       alu_srcb, ext_op;

  // Classify the instruction and pick its ALU operation and operand controls.
  always_comb begin
    kind     = K_ILL;
    dec_alu  = ALU_NOP;
    dec_srcb = 1'b0;
    dec_ext  = 1'b0;
    case (opcode)
      6'h00: begin
        kind = K_R;
        case (funct)
          6'h20, 6'h21: dec_alu = ALU_ADD;
          6'h22, 6'h23: dec_alu = ALU_SUB;
          6'h24:        dec_alu = ALU_AND;
          6'h25:        dec_alu = ALU_OR;
          6'h27:        dec_alu = ALU_NOR;
          6'h2a:        dec_alu = ALU_SLT;
          6'h08:        kind    = K_JR;
`ifdef CTRL_SHIFT_EN
          6'h00:        dec_alu = ALU_SLL;
          6'h02:        dec_alu = ALU_SRL;
          6'h04:        dec_alu = ALU_SLLV;
          6'h06:        dec_alu = ALU_SRLV;
`endif
          default:      kind    = K_ILL;
        endcase
      end
      6'h02: kind = K_J;
      6'h03: kind = K_JAL;
      6'h04: begin kind = K_BEQ; dec_alu = ALU_SUB; end
      6'h23: begin kind = K_LW;  dec_alu = ALU_ADD; dec_srcb = 1'b1; dec_ext = 1'b1; end
      6'h2b: begin kind = K_SW;  dec_alu = ALU_ADD; dec_srcb = 1'b1; dec_ext = 1'b1; end
      6'h08: begin kind = K_IMM; dec_alu = ALU_ADD; dec_srcb = 1'b1; dec_ext = 1'b1; end
      6'h0d: begin kind = K_IMM; dec_alu = ALU_OR;  dec_srcb = 1'b1; end
`ifdef CTRL_SHIFT_EN
      6'h0f: begin kind = K_IMM; dec_alu = ALU_LUI; dec_srcb = 1'b1; end
`endif
      default: kind = K_ILL;
    endcase
  end

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IF;
    else       state <= next_state;
  end

  // Next-state and raw control outputs for the current state.
  always_comb begin
    next_state = state;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    rf_wr      = 1'b0;
    dm_wr      = 1'b0;
    dm_rd      = 1'b0;
    ill        = 1'b0;
    retire     = 1'b0;
    npc_op     = 2'd0;
    gpr_sel    = 2'd0;
    wd_sel     = 2'd0;
    alu_op     = ALU_NOP;
    alu_srcb   = 1'b0;
    ext_op     = 1'b0;
    case (state)
      S_IF: begin
        pc_wr = mem_rdy;
        ir_wr = mem_rdy;
        if (mem_rdy) next_state = S_ID;
      end
      S_ID: begin
        case (kind)
          K_J:     begin pc_wr = 1'b1; npc_op = 2'd2; retire = 1'b1; next_state = S_IF; end
          K_JR:    begin pc_wr = 1'b1; npc_op = 2'd3; retire = 1'b1; next_state = S_IF; end
          K_JAL:   next_state = S_WB;
          K_ILL:   begin ill = 1'b1; next_state = S_IF; end
          default: next_state = S_EX;
        endcase
      end
      S_EX: begin
        alu_op   = dec_alu;
        alu_srcb = dec_srcb;
        ext_op   = dec_ext;
        if (kind == K_BEQ) begin
          pc_wr      = zero;
          npc_op     = 2'd1;
          retire     = 1'b1;
          next_state = S_IF;
        end else if (kind == K_LW || kind == K_SW) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        dm_rd = (kind == K_LW);
        dm_wr = (kind == K_SW) && mem_rdy;
        if (mem_rdy) begin
          if (kind == K_SW) begin
            retire     = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        rf_wr      = 1'b1;
        retire     = 1'b1;
        next_state = S_IF;
        case (kind)
          K_R: begin
            alu_op = dec_alu; alu_srcb = dec_srcb; ext_op = dec_ext;
          end
          K_IMM: begin
            gpr_sel = 2'd1;
            alu_op = dec_alu; alu_srcb = dec_srcb; ext_op = dec_ext;
          end
          K_LW:  begin gpr_sel = 2'd1; wd_sel = 2'd1; end
          K_JAL: begin gpr_sel = 2'd2; wd_sel = 2'd2; pc_wr = 1'b1; npc_op = 2'd2; end
          default: ;
        endcase
      end
      default: next_state = S_IF;
    endcase
  end

  // Hold every output at zero while reset is asserted.
  always_comb begin
    PCWr    = rstn & pc_wr;
    IRWr    = rstn & ir_wr;
    RFWr    = rstn & rf_wr;
    DMWr    = rstn & dm_wr;
    DMRd    = rstn & dm_rd;
    illegal = rstn & ill;
    ALUSrcB = rstn & alu_srcb;
    EXTOp   = rstn & ext_op;
    NPCOp   = rstn ? npc_op  : 2'd0;
    ALUop   = rstn ? alu_op  : ALU_NOP;
    GPRSel  = rstn ? gpr_sel : 2'd0;
    WDSel   = rstn ? wd_sel  : 2'd0;
  end

  // Retire counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl with a phase-level reference model.
// Honours CTRL_SHIFT_EN the same way the design does.
module tb_mc_ctrl;

  localparam int CW = 3;
`ifdef CTRL_SHIFT_EN
  localparam bit SHIFT_ON = 1'b1;
`else
  localparam bit SHIFT_ON = 1'b0;
`endif

  localparam int K_ILL = 0, K_R = 1, K_JR = 2, K_J = 3, K_JAL = 4,
                 K_BEQ = 5, K_LW = 6, K_SW = 7, K_IMM = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [5:0]    opcode = '0, funct = '0;
  logic          zero = 1'b0, mem_rdy = 1'b1;
  logic          PCWr, IRWr, RFWr, DMWr, DMRd, ALUSrcB, EXTOp, illegal;
  logic [1:0]    NPCOp, GPRSel, WDSel;
  logic [3:0]    ALUop;
  logic [CW-1:0] retired;

  typedef struct packed {
    logic       pcwr, irwr, rfwr, dmwr, dmrd;
    logic [1:0] npc;
    logic [3:0] alu;
    logic       srcb, ext;
    logic [1:0] gpr, wd;
    logic       ill;
  } outs_t;

  outs_t      expRec;
  logic       expValid = 1'b0;
  int         expRet = 0;
  int         expRetV = 0;
  int         checks = 0, errors = 0, dmrdCount = 0;
  logic [5:0] curOp = '0, curFn = '0;
  logic       curRst = 1'b0;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_rdy(mem_rdy), .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
    .DMRd(DMRd), .NPCOp(NPCOp), .ALUop(ALUop), .ALUSrcB(ALUSrcB),
    .EXTOp(EXTOp), .GPRSel(GPRSel), .WDSel(WDSel), .illegal(illegal),
    .retired(retired)
  );

  // What kind of instruction an encoding is, from the supported list.
  function automatic int kindOf(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:
        case (fn)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a: return K_R;
          6'h08: return K_JR;
          6'h00, 6'h02, 6'h04, 6'h06: return SHIFT_ON ? K_R : K_ILL;
          default: return K_ILL;
        endcase
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h04: return K_BEQ;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h08, 6'h0d: return K_IMM;
      6'h0f: return SHIFT_ON ? K_IMM : K_ILL;
      default: return K_ILL;
    endcase
  endfunction

  // ALU code each instruction uses.
  function automatic logic [3:0] aluOf(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: return 4'd1;
        6'h22, 6'h23: return 4'd2;
        6'h24: return 4'd3;
        6'h25: return 4'd4;
        6'h27: return 4'd5;
        6'h2a: return 4'd6;
        6'h00: return 4'd7;
        6'h02: return 4'd8;
        6'h04: return 4'd9;
        6'h06: return 4'd10;
        default: return 4'd0;
      endcase
    end
    case (op)
      6'h04: return 4'd2;
      6'h23, 6'h2b, 6'h08: return 4'd1;
      6'h0d: return 4'd4;
      6'h0f: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and publish its expectation.
  task automatic applyStimulus(input outs_t o, input logic mr, input logic zz);
    @(negedge clk);
    rstn     = curRst;
    opcode   = curOp;
    funct    = curFn;
    zero     = zz;
    mem_rdy  = mr;
    expRec   = o;
    expRetV  = expRet;
    expValid = 1'b1;
  endtask

  task automatic checkOutput();
    chk("PCWr",    PCWr,    expRec.pcwr);
    chk("IRWr",    IRWr,    expRec.irwr);
    chk("RFWr",    RFWr,    expRec.rfwr);
    chk("DMWr",    DMWr,    expRec.dmwr);
    chk("DMRd",    DMRd,    expRec.dmrd);
    chk("NPCOp",   NPCOp,   expRec.npc);
    chk("ALUop",   ALUop,   expRec.alu);
    chk("ALUSrcB", ALUSrcB, expRec.srcb);
    chk("EXTOp",   EXTOp,   expRec.ext);
    chk("GPRSel",  GPRSel,  expRec.gpr);
    chk("WDSel",   WDSel,   expRec.wd);
    chk("illegal", illegal, expRec.ill);
    chk("retired", retired, expRetV);
  endtask

  // Compare every driven cycle, settled well after the falling edge.
  always @(negedge clk) begin
    #2;
    if (expValid) begin
      checkOutput();
      if (DMRd === 1'b1) dmrdCount++;
    end
  end

  // Build and play one instruction phase by phase; returns its cycle count.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int ifStall, input int memStall, output int cyc);
    outs_t o;
    int k;
    logic [3:0] a;
    logic useImm, sgn;
    k = kindOf(op, fn);
    a = aluOf(op, fn);
    useImm = (k == K_IMM || k == K_LW || k == K_SW);
    sgn = (op == 6'h08 || k == K_LW || k == K_SW);
    curOp = op; curFn = fn;
    cyc = 0;
    for (int i = 0; i < ifStall; i++) begin
      o = '0; applyStimulus(o, 1'b0, z); cyc++;
    end
    o = '0; o.pcwr = 1'b1; o.irwr = 1'b1;
    applyStimulus(o, 1'b1, z); cyc++;
    o = '0;
    if (k == K_ILL) o.ill = 1'b1;
    if (k == K_J)  begin o.pcwr = 1'b1; o.npc = 2'd2; end
    if (k == K_JR) begin o.pcwr = 1'b1; o.npc = 2'd3; end
    applyStimulus(o, 1'b1, ~z); cyc++;
    if (k == K_R || k == K_IMM || k == K_BEQ || k == K_LW || k == K_SW) begin
      o = '0; o.alu = a; o.srcb = useImm; o.ext = sgn;
      if (k == K_BEQ) begin o.pcwr = z; o.npc = 2'd1; end
      applyStimulus(o, 1'b1, z); cyc++;
    end
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < memStall; i++) begin
        o = '0; o.dmrd = (k == K_LW);
        applyStimulus(o, 1'b0, ~z); cyc++;
      end
      o = '0; o.dmrd = (k == K_LW); o.dmwr = (k == K_SW);
      applyStimulus(o, 1'b1, ~z); cyc++;
    end
    if (k == K_R || k == K_IMM || k == K_LW || k == K_JAL) begin
      o = '0; o.rfwr = 1'b1;
      o.gpr = (k == K_R) ? 2'd0 : (k == K_JAL) ? 2'd2 : 2'd1;
      o.wd  = (k == K_LW) ? 2'd1 : (k == K_JAL) ? 2'd2 : 2'd0;
      if (k == K_R || k == K_IMM) begin o.alu = a; o.srcb = useImm; o.ext = sgn; end
      if (k == K_JAL) begin o.pcwr = 1'b1; o.npc = 2'd2; end
      applyStimulus(o, 1'b1, ~z); cyc++;
    end
    if (k != K_ILL) expRet = (expRet + 1) % (1 << CW);
  endtask

  task automatic checkRetired(input string name, input int v);
    @(posedge clk);
    #1;
    chk(name, retired, v);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    outs_t o;
    int cyc, d0;
    // Reset held for three cycles with memory ready.
    curRst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      o = '0; applyStimulus(o, 1'b1, 1'b0);
    end
    curRst = 1'b1;

    runInstr(6'h00, 6'h20, 1'b0, 0, 0, cyc); chk("cycles_add", cyc, 4);
    checkRetired("retired_after_add", 1);
    d0 = dmrdCount;
    runInstr(6'h23, 6'h00, 1'b0, 0, 2, cyc); chk("cycles_lw", cyc, 7);
    checkRetired("retired_after_lw", 2);
    chk("dmrd_cycles_lw", dmrdCount - d0, 3);
    runInstr(6'h04, 6'h00, 1'b1, 0, 0, cyc); chk("cycles_beq_taken", cyc, 3);
    runInstr(6'h04, 6'h00, 1'b0, 0, 0, cyc); chk("cycles_beq_not", cyc, 3);
    runInstr(6'h03, 6'h00, 1'b0, 0, 0, cyc); chk("cycles_jal", cyc, 3);
    runInstr(6'h02, 6'h00, 1'b0, 0, 0, cyc); chk("cycles_j", cyc, 2);
    runInstr(6'h00, 6'h08, 1'b0, 0, 0, cyc); chk("cycles_jr", cyc, 2);
    runInstr(6'h2b, 6'h00, 1'b0, 1, 1, cyc); chk("cycles_sw_stalled", cyc, 6);
    checkRetired("retired_wrap", 0);
    runInstr(6'h0d, 6'h00, 1'b0, 0, 0, cyc); chk("cycles_ori", cyc, 4);
    runInstr(6'h08, 6'h00, 1'b0, 0, 0, cyc); chk("cycles_addi", cyc, 4);
    runInstr(6'h0f, 6'h00, 1'b0, 0, 0, cyc); chk("cycles_lui", cyc, SHIFT_ON ? 4 : 2);
    runInstr(6'h00, 6'h00, 1'b0, 0, 0, cyc); chk("cycles_sll", cyc, SHIFT_ON ? 4 : 2);
    checkRetired("retired_after_sll", SHIFT_ON ? 4 : 2);
    runInstr(6'h3f, 6'h00, 1'b0, 0, 0, cyc); chk("cycles_bad_opcode", cyc, 2);
    runInstr(6'h00, 6'h01, 1'b0, 0, 0, cyc); chk("cycles_bad_funct", cyc, 2);
    runInstr(6'h00, 6'h22, 1'b1, 0, 0, cyc); chk("cycles_sub", cyc, 4);
    runInstr(6'h00, 6'h2a, 1'b0, 0, 0, cyc);
    runInstr(6'h00, 6'h27, 1'b0, 0, 0, cyc);

    // Reset in the middle of an add: nothing may be written or retired.
    curOp = 6'h00; curFn = 6'h20;
    o = '0; o.pcwr = 1'b1; o.irwr = 1'b1; applyStimulus(o, 1'b1, 1'b0);
    o = '0; applyStimulus(o, 1'b1, 1'b0);
    curRst = 1'b0; expRet = 0;
    o = '0; applyStimulus(o, 1'b1, 1'b0);
    o = '0; applyStimulus(o, 1'b1, 1'b0);
    curRst = 1'b1;
    runInstr(6'h00, 6'h20, 1'b0, 0, 0, cyc);
    checkRetired("retired_after_midreset", 1);

    @(negedge clk);
    expValid = 1'b0;
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the simple CPU datapath. Decodes the instruction register's opcode/funct fields, sequences each instruction through IF/ID/EX/MEM/WB states, and drives the write enables, mux selects and the ALUop code consumed by the ALU. Memory accesses use a ready handshake so instruction and data memory may stall. An instruction-retire counter is exported for debug and bench checking.

## Interface
Parameters:
- CNT_W, 32, width of the retire counter.

Ports:
- clk, input, 1, rising-edge clock.
- rstn, input, 1, asynchronous, active-low reset.
- opcode, input, 6, IR[31:26]; stable from the cycle after IF completes.
- funct, input, 6, IR[5:0].
- zero, input, 1, ALU Zero flag, sampled in EX.
- mem_rdy, input, 1, memory access done this cycle (IF fetch or MEM access).
- PCWr, output, 1, PC write enable.
- IRWr, output, 1, IR write enable.
- RFWr, output, 1, register file write enable.
- DMWr, output, 1, data memory write strobe.
- DMRd, output, 1, data memory read request.
- NPCOp, output, 2, 0=PC+4, 1=branch target, 2=jump target, 3=rs (jr).
- ALUop, output, 4, ALU operation, using the ALU_* codes in decode.v: NOP 0, ADD 1, SUB 2, AND 3, OR 4, NOR 5, SLT 6, SLL 7, SRL 8, SLLV 9, SRLV 10, LUI 11.
- ALUSrcB, output, 1, 0=rt, 1=extended immediate.
- EXTOp, output, 1, 0=zero-extend, 1=sign-extend.
- GPRSel, output, 2, write register: 0=rd, 1=rt, 2=$31.
- WDSel, output, 2, write data: 0=ALU, 1=memory, 2=PC+4.
- illegal, output, 1, one-cycle pulse in ID for an unsupported encoding.
- retired, output, CNT_W, count of completed instructions.

## Operation
- States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4; 3-bit state register.
- S_IF: DMRd=0; IRWr=PCWr=mem_rdy, NPCOp=0. Stay while mem_rdy=0; go to S_ID when mem_rdy=1.
- S_ID: decode. j → PCWr, NPCOp=2, retire, go to S_IF. jal → S_WB. jr → PCWr, NPCOp=3, retire, go to S_IF. Illegal → illegal=1, no writes, no retire, go to S_IF. All others → S_EX.
- S_EX: ALUop/ALUSrcB/EXTOp driven per instruction. beq: ALUop=SUB; PCWr=zero, NPCOp=1; retire; go to S_IF. lw/sw: ALUop=ADD, ALUSrcB=1, EXTOp=1; go to S_MEM. R-type/addi/ori/lui: go to S_WB.
- S_MEM: lw → DMRd=1; sw → DMWr=mem_rdy. Stay until mem_rdy=1. sw then retires and goes to S_IF; lw goes to S_WB.
- S_WB: RFWr=1; retire; go to S_IF. R-type: GPRSel=0, WDSel=0. addi/ori/lui: GPRSel=1, WDSel=0. lw: GPRSel=1, WDSel=1. jal: GPRSel=2, WDSel=2, with PCWr=1 and NPCOp=2 asserted in the same cycle.
- ALUop is held in S_WB so that the ALU output is stable while it is written back.
- Decode: R-type (opcode 0) funct add/addu=ADD, sub/subu=SUB, and=AND, or=OR, nor=NOR, slt=SLT, sll=SLL, srl=SRL, sllv=SLLV, srlv=SRLV, jr=08. addi=ADD with sign-extend; ori=OR with zero-extend; lui=LUI.
- retired increments by 1 on each retire event and wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0 (NPCOp=0, ALUop=NOP).

## Timing
- Outputs are combinational from the state register plus opcode/funct. The state register and retired are the only flops.
- Minimum cycle counts: j/jr 2; beq/jal 3; R-type/addi/ori/lui/sw 4; lw 5. Each cycle with mem_rdy=0 in S_IF or S_MEM adds one cycle.
- Reset: rstn=0 forces state=S_IF and retired=0 immediately. While rstn=0, every output is 0.
- The first fetch is allowed on the first rising edge after rstn deasserts.
- Reset mid-instruction abandons the instruction; no partial write completes after the reset is asserted.
- mem_rdy is ignored outside S_IF/S_MEM. zero is ignored outside S_EX.

## Configuration
- CTRL_SHIFT_EN defined: sll, srl, sllv, srlv and lui decode as specified above.
- CTRL_SHIFT_EN undefined: those five encodings decode as illegal (illegal pulse, no retire), and ALUop never takes the values 7–11.

## Test plan
- Reset: hold rstn=0 for 3 cycles with mem_rdy=1 → all outputs 0 and retired=0. First edge after release → IRWr=PCWr=1.
- add (op 0, funct 0x20), mem_rdy=1 → 4 cycles; ALUop=1 in EX; RFWr=1 with GPRSel=0 in WB; retired goes 0→1.
- lw (0x23) with mem_rdy held low for 2 cycles in S_MEM → 7 cycles total; DMRd=1 for 3 cycles; WB has WDSel=1, GPRSel=1.
- beq (0x04): zero=1 → PCWr=1 and NPCOp=1 in EX. zero=0 → PCWr=0. Each case takes 3 cycles and retires.
- jal (0x03) → WB has RFWr=1, GPRSel=2, WDSel=2, PCWr=1, NPCOp=2; 3 cycles total.
- sll (funct 0x00): with CTRL_SHIFT_EN → ALUop=7 in EX. Without it → illegal pulses in ID and retired is unchanged.
